decode_id: RTL and testbench
============================

# decode_ID

Decode stage of the RV32I five-stage pipeline, between the IF/ID register and the ID/EX register. Holds the 32×32 register file and decodes the 32-bit instruction into the control bundle the ID/EX register latches. Generates the immediate and detects load-use hazards. Drives the stall and clear controls for the IF/ID and ID/EX registers.

## Interface
Parameters:
- none (PC width fixed at 9 bits, XLEN fixed at 32)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Instr_ID  in  32  instruction from IF/ID
- PC_ID  in  9  PC of Instr_ID (passed through unchanged)
- RegWEn_WB  in  1  write-back enable
- Rd_WB  in  5  write-back destination
- WD_WB  in  32  write-back data
- Rd_EX  in  5  destination of the instruction now in EX
- WBSel_EX  in  2  write-back select of the instruction now in EX (1 = load)
- flush  in  1  taken branch/jump resolved in EX
- Imm_ID  out  32  sign-extended immediate
- RD1_ID, RD2_ID  out  32  register read data
- Rd_ID, Rs1_ID, Rs2_ID  out  5  instruction fields [11:7], [19:15], [24:20]
- PCsel_ID, RegWEn_ID, Asel_ID, Bsel_ID, MemRW_ID  out  1  control
- WBSel_ID  out  2  0 = ALU, 1 = memory, 2 = PC+4
- WordSizeSel_ID  out  3  funct3 (Instr[14:12]) for every opcode
- ALUSel_ID  out  4  ALU operation
- stall  out  1  hold PC and IF/ID
- clear_EX  out  1  zero ID/EX on the next edge
- illegal  out  1  sticky illegal-opcode flag

## Operation
- Register file: x1..x31 are 32-bit flops; x0 reads 0 and writes to it are ignored.
- Write: on posedge clk when RegWEn_WB=1 and Rd_WB≠0, reg[Rd_WB] <= WD_WB.
- Read: combinational. Write-first bypass: if RegWEn_WB=1, Rd_WB≠0 and Rd_WB equals the read address, the read returns WD_WB.
- ALUSel encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Values 11–15 are unused.
- R-type (0110011): ALUSel from funct3/funct7[5]; RegWEn=1; Bsel=0; Asel=0.
- I-ALU (0010011): as R-type with Bsel=1. funct7[5] is honoured only for SRAI; SUB is never produced.
- LOAD (0000011): ADD, Bsel=1, RegWEn=1, WBSel=1.
- STORE (0100011): ADD, Bsel=1, MemRW=1, RegWEn=0.
- BRANCH (1100011): PCsel=1, Asel=1, Bsel=1, ADD, RegWEn=0. EX qualifies the branch with its RD1/RD2 compare per WordSizeSel.
- JAL (1101111): PCsel=1, Asel=1, Bsel=1, ADD, RegWEn=1, WBSel=2.
- JALR (1100111): PCsel=1, Asel=0, Bsel=1, ADD, RegWEn=1, WBSel=2.
- LUI (0110111): PASS_B, Bsel=1, RegWEn=1.
- AUIPC (0010111): Asel=1, Bsel=1, ADD, RegWEn=1.
- Immediates follow the standard I/S/B/U/J formats, sign-extended from Instr[31]. B and J immediates have bit 0 = 0. R-type Imm = 0.
- Any other opcode: all control outputs 0 (NOP). On posedge clk, illegal <= 1, unless stall or flush is high that cycle.
- Rs1 usage: R, I-ALU, LOAD, STORE, BRANCH, JALR.
- Rs2 usage: R, STORE, BRANCH.
- Load-use hazard: hz = (WBSel_EX==1) & (Rd_EX≠0) & ((uses_rs1 & Rd_EX==Rs1_ID) | (uses_rs2 & Rd_EX==Rs2_ID)).
- stall = hz & ~flush.
- clear_EX = hz | flush.
- flush has priority: when flush=1, stall=0 and the wrong-path instruction is squashed.

## Timing
- Decode, immediate, read data, stall and clear_EX are combinational from their inputs in the same cycle.
- A register write commits at the write edge. The bypass makes it visible to a read in the same cycle.
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in MEM, so Rd_EX no longer matches.
- Reset values, held while rst=1:
  - all 31 registers = 0
  - illegal = 0
- All other outputs are functions of the inputs. With Instr_ID=0 (opcode 0000000, illegal) they are all 0, and illegal does not set while rst=1.
- Reset mid-write: the write is discarded and the register stays 0.
- Simultaneous WB write and hazard: the write still commits, because the register file is never stalled.

## Test plan
- Reset, then read x1..x31 → all 0. Write x0=0xDEADBEEF → x0 reads 0.
- Rd_WB=5, WD_WB=0x12345678, RegWEn_WB=1, and same-cycle `add x6,x5,x5` → RD1=RD2=0x12345678 before the edge; x5 holds it after the edge.
- WBSel_EX=1, Rd_EX=3, Instr=`addi x4,x3,-1` → stall=1, clear_EX=1, Imm=0xFFFFFFFF. Next cycle with Rd_EX=0 → stall=0.
- Same hazard with flush=1 → stall=0, clear_EX=1.
- Opcode vectors:
  - `lui x1,0x80000` → Imm=0x80000000, ALUSel=10
  - `jal x1,-4` → Imm=0xFFFFFFFC, PCsel=1, WBSel=2
  - `sw x2,8(x1)` → MemRW=1, Imm=8
  - `srai x1,x1,3` → ALUSel=7
- Instr=0xFFFFFFFF → all control outputs 0, illegal=1 after the edge and held. After rst → illegal=0.

Source files
------------

// File: rtl/decode_id.sv
// RV32I decode stage: register file with write-first bypass, control decode,
// immediate generation and load-use hazard detection.
module decode_id (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr_ID,
    input  logic [8:0]  PC_ID,
    input  logic        RegWEn_WB,
    input  logic [4:0]  Rd_WB,
    input  logic [31:0] WD_WB,
    input  logic [4:0]  Rd_EX,
    input  logic [1:0]  WBSel_EX,
    input  logic        flush,
    output logic [31:0] Imm_ID,
    output logic [31:0] RD1_ID,
    output logic [31:0] RD2_ID,
    output logic [4:0]  Rd_ID,
    output logic [4:0]  Rs1_ID,
    output logic [4:0]  Rs2_ID,
    output logic        PCsel_ID,
    output logic        RegWEn_ID,
    output logic        Asel_ID,
    output logic        Bsel_ID,
    output logic        MemRW_ID,
    output logic [1:0]  WBSel_ID,
    output logic [2:0]  WordSizeSel_ID,
    output logic [3:0]  ALUSel_ID,
    output logic        stall,
    output logic        clear_EX,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    logic [31:0] regs_r [1:31];
    logic        illegal_r;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        alt_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;

    imm_fmt_t    imm_fmt_s;
    logic [31:0] imm_s;
    logic [3:0]  alu_sel_s;
    logic        pcsel_s;
    logic        regwen_s;
    logic        asel_s;
    logic        bsel_s;
    logic        memrw_s;
    logic [1:0]  wbsel_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        illegal_op_s;
    logic        hazard_s;
    logic        stall_s;
    logic        wb_write_s;
    logic        unused_pc_s;

    // funct7[5] selects SUB only for register-register ops; it always selects SRA
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt & is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        if (addr == 5'd0) begin
            data = 32'd0;
        end else if (wb_write_s && (Rd_WB == addr)) begin
            data = WD_WB;
        end else begin
            data = regs_r[addr];
        end
        return data;
    endfunction

    assign opcode_s   = Instr_ID[6:0];
    assign rd_s       = Instr_ID[11:7];
    assign funct3_s   = Instr_ID[14:12];
    assign rs1_s      = Instr_ID[19:15];
    assign rs2_s      = Instr_ID[24:20];
    assign alt_s      = Instr_ID[30];
    assign wb_write_s = RegWEn_WB & (Rd_WB != 5'd0);

    // The PC is carried alongside in the pipeline register, not consumed here
    assign unused_pc_s = ^PC_ID;

    // Control decode; unrecognised opcodes decode to a NOP
    always_comb begin
        imm_fmt_s    = IMM_NONE;
        alu_sel_s    = ALU_ADD;
        pcsel_s      = 1'b0;
        regwen_s     = 1'b0;
        asel_s       = 1'b0;
        bsel_s       = 1'b0;
        memrw_s      = 1'b0;
        wbsel_s      = WB_ALU;
        use_rs1_s    = 1'b0;
        use_rs2_s    = 1'b0;
        illegal_op_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                alu_sel_s = alu_op(funct3_s, alt_s, 1'b1);
                regwen_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_IMM: begin
                imm_fmt_s = IMM_I;
                alu_sel_s = alu_op(funct3_s, alt_s, 1'b0);
                regwen_s  = 1'b1;
                bsel_s    = 1'b1;
                use_rs1_s = 1'b1;
            end
            OP_LOAD: begin
                imm_fmt_s = IMM_I;
                regwen_s  = 1'b1;
                bsel_s    = 1'b1;
                wbsel_s   = WB_MEM;
                use_rs1_s = 1'b1;
            end
            OP_STORE: begin
                imm_fmt_s = IMM_S;
                bsel_s    = 1'b1;
                memrw_s   = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_BRANCH: begin
                imm_fmt_s = IMM_B;
                pcsel_s   = 1'b1;
                asel_s    = 1'b1;
                bsel_s    = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OP_JAL: begin
                imm_fmt_s = IMM_J;
                pcsel_s   = 1'b1;
                asel_s    = 1'b1;
                bsel_s    = 1'b1;
                regwen_s  = 1'b1;
                wbsel_s   = WB_PC4;
            end
            OP_JALR: begin
                imm_fmt_s = IMM_I;
                pcsel_s   = 1'b1;
                bsel_s    = 1'b1;
                regwen_s  = 1'b1;
                wbsel_s   = WB_PC4;
                use_rs1_s = 1'b1;
            end
            OP_LUI: begin
                imm_fmt_s = IMM_U;
                alu_sel_s = ALU_PASS_B;
                bsel_s    = 1'b1;
                regwen_s  = 1'b1;
            end
            OP_AUIPC: begin
                imm_fmt_s = IMM_U;
                asel_s    = 1'b1;
                bsel_s    = 1'b1;
                regwen_s  = 1'b1;
            end
            default: begin
                illegal_op_s = 1'b1;
            end
        endcase
    end

    // Immediate assembly, sign-extended from instruction bit 31
    always_comb begin
        case (imm_fmt_s)
            IMM_I:   imm_s = {{20{Instr_ID[31]}}, Instr_ID[31:20]};
            IMM_S:   imm_s = {{20{Instr_ID[31]}}, Instr_ID[31:25], Instr_ID[11:7]};
            IMM_B:   imm_s = {{19{Instr_ID[31]}}, Instr_ID[31], Instr_ID[7],
                              Instr_ID[30:25], Instr_ID[11:8], 1'b0};
            IMM_U:   imm_s = {Instr_ID[31:12], 12'd0};
            IMM_J:   imm_s = {{11{Instr_ID[31]}}, Instr_ID[31], Instr_ID[19:12],
                              Instr_ID[20], Instr_ID[30:21], 1'b0};
            default: imm_s = 32'd0;
        endcase
    end

    // A load in EX cannot forward yet, so a dependent consumer waits one bubble
    always_comb begin
        hazard_s = (WBSel_EX == WB_MEM) && (Rd_EX != 5'd0) &&
                   ((use_rs1_s && (Rd_EX == rs1_s)) || (use_rs2_s && (Rd_EX == rs2_s)));
        stall_s  = hazard_s & ~flush;
    end

    // Register file write port; x0 has no storage and the file is never stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_write_s) begin
            regs_r[Rd_WB] <= WD_WB;
        end
    end

    // Sticky illegal flag; wrong-path or stalled instructions do not count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else if (illegal_op_s && !stall_s && !flush) begin
            illegal_r <= 1'b1;
        end
    end

    assign RD1_ID         = read_port(rs1_s);
    assign RD2_ID         = read_port(rs2_s);
    assign Imm_ID         = imm_s;
    assign Rd_ID          = rd_s;
    assign Rs1_ID         = rs1_s;
    assign Rs2_ID         = rs2_s;
    assign PCsel_ID       = pcsel_s;
    assign RegWEn_ID      = regwen_s;
    assign Asel_ID        = asel_s;
    assign Bsel_ID        = bsel_s;
    assign MemRW_ID       = memrw_s;
    assign WBSel_ID       = wbsel_s;
    assign WordSizeSel_ID = funct3_s;
    assign ALUSel_ID      = alu_sel_s;
    assign stall          = stall_s;
    assign clear_EX       = hazard_s | flush;
    assign illegal        = illegal_r;

endmodule

// File: tb/tb_decode_id.sv
// Bench for decode_id: directed scenarios followed by random instructions
// checked against an encoder-driven reference model.
module tb_decode_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr_ID;
    logic [8:0]  PC_ID;
    logic        RegWEn_WB;
    logic [4:0]  Rd_WB;
    logic [31:0] WD_WB;
    logic [4:0]  Rd_EX;
    logic [1:0]  WBSel_EX;
    logic        flush;
    logic [31:0] Imm_ID, RD1_ID, RD2_ID;
    logic [4:0]  Rd_ID, Rs1_ID, Rs2_ID;
    logic        PCsel_ID, RegWEn_ID, Asel_ID, Bsel_ID, MemRW_ID;
    logic [1:0]  WBSel_ID;
    logic [2:0]  WordSizeSel_ID;
    logic [3:0]  ALUSel_ID;
    logic        stall, clear_EX, illegal;

    always #5 clk = ~clk;

    decode_id dut (
        .clk(clk), .rst(rst), .Instr_ID(Instr_ID), .PC_ID(PC_ID),
        .RegWEn_WB(RegWEn_WB), .Rd_WB(Rd_WB), .WD_WB(WD_WB),
        .Rd_EX(Rd_EX), .WBSel_EX(WBSel_EX), .flush(flush),
        .Imm_ID(Imm_ID), .RD1_ID(RD1_ID), .RD2_ID(RD2_ID),
        .Rd_ID(Rd_ID), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
        .PCsel_ID(PCsel_ID), .RegWEn_ID(RegWEn_ID), .Asel_ID(Asel_ID),
        .Bsel_ID(Bsel_ID), .MemRW_ID(MemRW_ID), .WBSel_ID(WBSel_ID),
        .WordSizeSel_ID(WordSizeSel_ID), .ALUSel_ID(ALUSel_ID),
        .stall(stall), .clear_EX(clear_EX), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        pcsel, regwen, asel, bsel, memrw;
        logic [1:0]  wbsel;
        logic        u1, u2;
    } exp_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] mregs [32];
    logic        mill;

    // funct3 for each ALU code 0..9 (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND)
    int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int i_codes [9] = '{0, 2, 3, 4, 5, 6, 7, 8, 9};
    int bad_ops [4] = '{'h0F, 'h73, 'h7F, 'h00};

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWEn_WB && Rd_WB == a) return WD_WB;
        return mregs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic full_check(input string tag, input exp_t e, input bit chk_imm);
        logic [4:0] a1, a2;
        logic hz;
        a1 = Instr_ID[19:15];
        a2 = Instr_ID[24:20];
        hz = (WBSel_EX == 2'd1) && (Rd_EX != 5'd0) &&
             ((e.u1 && Rd_EX == a1) || (e.u2 && Rd_EX == a2));
        if (chk_imm) chk({tag, ".imm"}, Imm_ID, e.imm);
        chk({tag, ".alu"},    32'(ALUSel_ID), 32'(e.alu));
        chk({tag, ".pcsel"},  32'(PCsel_ID),  32'(e.pcsel));
        chk({tag, ".regwen"}, 32'(RegWEn_ID), 32'(e.regwen));
        chk({tag, ".asel"},   32'(Asel_ID),   32'(e.asel));
        chk({tag, ".bsel"},   32'(Bsel_ID),   32'(e.bsel));
        chk({tag, ".memrw"},  32'(MemRW_ID),  32'(e.memrw));
        chk({tag, ".wbsel"},  32'(WBSel_ID),  32'(e.wbsel));
        chk({tag, ".wss"},    32'(WordSizeSel_ID), 32'(Instr_ID[14:12]));
        chk({tag, ".rs1"},    32'(Rs1_ID), 32'(a1));
        chk({tag, ".rs2"},    32'(Rs2_ID), 32'(a2));
        chk({tag, ".rd"},     32'(Rd_ID),  32'(Instr_ID[11:7]));
        chk({tag, ".rd1"},    RD1_ID, rd_model(a1));
        chk({tag, ".rd2"},    RD2_ID, rd_model(a2));
        chk({tag, ".stall"},  32'(stall),    32'(hz && !flush));
        chk({tag, ".clear"},  32'(clear_EX), 32'(hz || flush));
        chk({tag, ".illegal"}, 32'(illegal), 32'(mill));
    endtask

    // One clock edge with the reference model following the architectural rules
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mill = 1'b0;
        end else begin
            if (RegWEn_WB && Rd_WB != 5'd0) mregs[Rd_WB] = WD_WB;
            if (!legal_op(Instr_ID[6:0]) && !flush) mill = 1'b1;
        end
    endtask

    task automatic quiet();
        RegWEn_WB = 1'b0; Rd_WB = 5'd0; WD_WB = 32'd0;
        Rd_EX = 5'd0; WBSel_EX = 2'd0; flush = 1'b0;
    endtask

    task automatic gen(input int kind, output logic [31:0] ins, output exp_t e);
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [19:0] u20;
        int code;
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        f3 = 3'($urandom); i12 = 12'($urandom);
        e = '0;
        case (kind)
            0: begin
                code = $urandom_range(0, 9);
                ins = enc_r((code == 1 || code == 7) ? 7'h20 : 7'h00, rs2, rs1,
                            3'(r_f3[code]), rd);
                e.alu = 4'(code); e.regwen = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1;
            end
            1: begin
                code = i_codes[$urandom_range(0, 8)];
                if (code == 2 || code == 6 || code == 7)
                    i12 = {(code == 7) ? 7'h20 : 7'h00, rs2};
                ins = enc_i(i12, rs1, 3'(r_f3[code]), rd, 7'h13);
                e.imm = 32'($signed(i12)); e.alu = 4'(code);
                e.bsel = 1'b1; e.regwen = 1'b1; e.u1 = 1'b1;
            end
            2: begin
                ins = enc_i(i12, rs1, f3, rd, 7'h03);
                e.imm = 32'($signed(i12)); e.bsel = 1'b1; e.regwen = 1'b1;
                e.wbsel = 2'd1; e.u1 = 1'b1;
            end
            3: begin
                ins = enc_s(i12, rs2, rs1, f3);
                e.imm = 32'($signed(i12)); e.bsel = 1'b1; e.memrw = 1'b1;
                e.u1 = 1'b1; e.u2 = 1'b1;
            end
            4: begin
                b13 = {i12, 1'b0};
                ins = enc_b(b13, rs2, rs1, f3);
                e.imm = 32'($signed(b13)); e.pcsel = 1'b1; e.asel = 1'b1;
                e.bsel = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1;
            end
            5: begin
                j21 = {20'($urandom), 1'b0};
                ins = enc_j(j21, rd);
                e.imm = 32'($signed(j21)); e.pcsel = 1'b1; e.asel = 1'b1;
                e.bsel = 1'b1; e.regwen = 1'b1; e.wbsel = 2'd2;
            end
            6: begin
                ins = enc_i(i12, rs1, f3, rd, 7'h67);
                e.imm = 32'($signed(i12)); e.pcsel = 1'b1; e.bsel = 1'b1;
                e.regwen = 1'b1; e.wbsel = 2'd2; e.u1 = 1'b1;
            end
            7, 8: begin
                u20 = 20'($urandom);
                ins = enc_u(u20, rd, (kind == 7) ? 7'h37 : 7'h17);
                e.imm = {u20, 12'd0}; e.bsel = 1'b1; e.regwen = 1'b1;
                e.alu = (kind == 7) ? 4'd10 : 4'd0; e.asel = (kind == 8);
            end
            default: begin
                ins = {25'($urandom), 7'(bad_ops[$urandom_range(0, 3)])};
            end
        endcase
    endtask

    initial begin
        exp_t e;
        logic [31:0] ins;
        int kind;

        rst = 1'b1; Instr_ID = 32'd0; PC_ID = 9'd0;
        quiet();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mill = 1'b0;

        // Reset: every output is zero for Instr=0 and illegal cannot set
        #2;
        e = '0;
        full_check("reset", e, 1'b1);
        tick();
        tick();
        #1 chk("reset.illegal_held", 32'(illegal), 32'd0);

        @(negedge clk);
        Instr_ID = 32'h0000_0013;
        rst = 1'b0;
        #1;
        for (int i = 1; i < 32; i++) begin
            Instr_ID = enc_r(7'h00, 5'(i), 5'(i), 3'd0, 5'd0);
            #1;
            chk($sformatf("regzero.x%0d.rd1", i), RD1_ID, 32'd0);
            chk($sformatf("regzero.x%0d.rd2", i), RD2_ID, 32'd0);
        end

        // Writes to x0 are dropped and never bypassed
        @(negedge clk);
        RegWEn_WB = 1'b1; Rd_WB = 5'd0; WD_WB = 32'hDEAD_BEEF;
        Instr_ID = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
        #1 chk("x0.bypass", RD1_ID, 32'd0);
        tick();
        @(negedge clk);
        quiet();
        #1 chk("x0.after", RD1_ID, 32'd0);

        // Same-cycle bypass, then the committed value
        @(negedge clk);
        RegWEn_WB = 1'b1; Rd_WB = 5'd5; WD_WB = 32'h1234_5678;
        Instr_ID = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
        #1;
        chk("byp.rd1", RD1_ID, 32'h1234_5678);
        chk("byp.rd2", RD2_ID, 32'h1234_5678);
        tick();
        @(negedge clk);
        quiet();
        #1 chk("byp.commit", RD1_ID, 32'h1234_5678);

        // Load-use hazard with a simultaneous write-back
        @(negedge clk);
        WBSel_EX = 2'd1; Rd_EX = 5'd3;
        RegWEn_WB = 1'b1; Rd_WB = 5'd7; WD_WB = 32'hCAFE_F00D;
        Instr_ID = enc_i(12'hFFF, 5'd3, 3'd0, 5'd4, 7'h13);
        #1;
        chk("hz.stall", 32'(stall), 32'd1);
        chk("hz.clear", 32'(clear_EX), 32'd1);
        chk("hz.imm", Imm_ID, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        quiet();
        #1;
        chk("hz.next.stall", 32'(stall), 32'd0);
        chk("hz.next.clear", 32'(clear_EX), 32'd0);
        Instr_ID = enc_r(7'h00, 5'd3, 5'd7, 3'd0, 5'd0);
        #1 chk("hz.write_commits", RD1_ID, 32'hCAFE_F00D);

        // Flush overrides the hazard
        @(negedge clk);
        WBSel_EX = 2'd1; Rd_EX = 5'd3; flush = 1'b1;
        Instr_ID = enc_i(12'hFFF, 5'd3, 3'd0, 5'd4, 7'h13);
        #1;
        chk("flush.stall", 32'(stall), 32'd0);
        chk("flush.clear", 32'(clear_EX), 32'd1);
        tick();
        @(negedge clk);
        quiet();

        // Directed opcode vectors
        Instr_ID = enc_u(20'h80000, 5'd1, 7'h37);
        #1;
        chk("lui.imm", Imm_ID, 32'h8000_0000);
        chk("lui.alu", 32'(ALUSel_ID), 32'd10);
        Instr_ID = enc_j(21'h1F_FFFC, 5'd1);
        #1;
        chk("jal.imm", Imm_ID, 32'hFFFF_FFFC);
        chk("jal.pcsel", 32'(PCsel_ID), 32'd1);
        chk("jal.wbsel", 32'(WBSel_ID), 32'd2);
        Instr_ID = enc_s(12'd8, 5'd2, 5'd1, 3'd2);
        #1;
        chk("sw.memrw", 32'(MemRW_ID), 32'd1);
        chk("sw.imm", Imm_ID, 32'd8);
        Instr_ID = enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 5'd1, 7'h13);
        #1 chk("srai.alu", 32'(ALUSel_ID), 32'd7);

        // Illegal opcode: NOP controls, gated by flush, sticky once set
        Instr_ID = 32'hFFFF_FFFF;
        flush = 1'b1;
        #1;
        e = '0;
        full_check("ill", e, 1'b0);
        tick();
        #1 chk("ill.flush_gated", 32'(illegal), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        tick();
        #1 chk("ill.set", 32'(illegal), 32'd1);
        @(negedge clk);
        Instr_ID = 32'h0000_0013;
        tick();
        #1 chk("ill.held", 32'(illegal), 32'd1);

        // Reset during a write discards it and clears illegal
        @(negedge clk);
        rst = 1'b1;
        RegWEn_WB = 1'b1; Rd_WB = 5'd9; WD_WB = 32'hA5A5_A5A5;
        tick();
        @(negedge clk);
        quiet();
        Instr_ID = enc_r(7'h00, 5'd9, 5'd9, 3'd0, 5'd0);
        rst = 1'b0;
        #1;
        chk("rstw.x9", RD1_ID, 32'd0);
        chk("rstw.illegal", 32'(illegal), 32'd0);

        // Random instruction stream against the reference model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            kind = $urandom_range(0, 9);
            gen(kind, ins, e);
            Instr_ID = ins;
            PC_ID = 9'($urandom);
            RegWEn_WB = 1'($urandom);
            Rd_WB = 5'($urandom);
            WD_WB = $urandom;
            WBSel_EX = 2'($urandom);
            Rd_EX = ($urandom_range(0, 2) == 0) ? ins[19:15] :
                    ($urandom_range(0, 2) == 0) ? ins[24:20] : 5'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            full_check($sformatf("rnd%0d.k%0d", n, kind), e, kind != 9);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
